sparce_sasa_table: RTL and testbench

SPARCE_SASA_TABLE -- requirements
Module: sparce_sasa_table

---
 rtl/rv32i_types_pkg.sv | 4 +
 rtl/sparce_sasa_table_pkg.sv | 39 +++
 rtl/sparce_sasa_table_if.sv | 24 ++
 rtl/sparce_sasa_table.sv | 119 +++++++++++
 tb/tb_sparce_sasa_table.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/rv32i_types_pkg.sv
// Base RV32I scalar types shared across the core.
package rv32i_types_pkg;
   typedef logic [31:0] word_t;
endpackage

// File: rtl/sparce_sasa_table_pkg.sv
// SASA skip-table types: config word offsets, INFO bit layout, entry record and write-FSM states.
package sparce_sasa_table_pkg;
   import rv32i_types_pkg::*;

   localparam word_t SASA_TAG_OFS  = 32'h0000_0000;
   localparam word_t SASA_INFO_OFS = 32'h0000_0004;
   localparam word_t SASA_CTRL_OFS = 32'h0000_0008;

   localparam int unsigned SASA_RS1_LSB   = 0;
   localparam int unsigned SASA_RS2_LSB   = 5;
   localparam int unsigned SASA_SKIP_LSB  = 10;
   localparam int unsigned SASA_COND_BIT  = 15;
   localparam int unsigned SASA_VALID_BIT = 16;
   localparam int unsigned SASA_FLUSH_BIT = 0;

   typedef logic [4:0] reg_idx_t;

   typedef struct packed {
      word_t    tag;
      reg_idx_t rs1;
      reg_idx_t rs2;
      reg_idx_t skip;
      logic     cond;
   } sasa_entry_t;

   typedef logic [0:0] sasa_state_t;
   localparam sasa_state_t SASA_IDLE     = 1'b0;
   localparam sasa_state_t SASA_TAG_HELD = 1'b1;

   function automatic sasa_entry_t sasa_decode_info(input word_t tag, input logic [15:0] info);
      sasa_entry_t e;
      e.tag  = tag;
      e.rs1  = info[SASA_RS1_LSB  +: 5];
      e.rs2  = info[SASA_RS2_LSB  +: 5];
      e.skip = info[SASA_SKIP_LSB +: 5];
      e.cond = info[SASA_COND_BIT];
      return e;
   endfunction
endpackage

// File: rtl/sparce_sasa_table_if.sv
// Lookup and config-write bus of the SASA skip table.
interface sparce_sasa_table_if;
   import rv32i_types_pkg::*;

   word_t      pc;
   word_t      sasa_addr;
   word_t      sasa_data;
   logic       sasa_wen;
   logic       sasa_hit;
   logic [4:0] sasa_rs1;
   logic [4:0] sasa_rs2;
   logic [4:0] sasa_insts_to_skip;
   logic       sasa_cond;

   modport master (
      output pc, sasa_addr, sasa_data, sasa_wen,
      input  sasa_hit, sasa_rs1, sasa_rs2, sasa_insts_to_skip, sasa_cond
   );

   modport slave (
      input  pc, sasa_addr, sasa_data, sasa_wen,
      output sasa_hit, sasa_rs1, sasa_rs2, sasa_insts_to_skip, sasa_cond
   );
endinterface

// File: rtl/sparce_sasa_table.sv
// Fully-associative SASA skip table: TAG/INFO config writes build entries, pc lookup answers one cycle later.
module sparce_sasa_table
   import rv32i_types_pkg::*;
   import sparce_sasa_table_pkg::*;
#(
   parameter int unsigned SASA_ENTRIES = 16,
   parameter word_t       SASA_ADDR    = 32'h0000_2000
) (
   input  logic                CLK,
   input  logic                nRST,
   sparce_sasa_table_if.slave  bus
);
   localparam int unsigned PTR_W = $clog2(SASA_ENTRIES);
   typedef logic [PTR_W-1:0] ptr_t;

   sasa_state_t             state;
   word_t                   tag_q;
   ptr_t                    wr_ptr;
   logic [SASA_ENTRIES-1:0] valid;
   sasa_entry_t             entries [SASA_ENTRIES];

   logic        wr_tag, wr_info, wr_flush, commit;
   logic        cm_hit, new_valid;
   ptr_t        cm_idx, slot;
   sasa_entry_t new_ent;

   logic     look_hit, look_cond;
   reg_idx_t look_rs1, look_rs2, look_skip;

   logic     hit_q, cond_q;
   reg_idx_t rs1_q, rs2_q, skip_q;

   assign wr_tag   = bus.sasa_wen && (bus.sasa_addr == SASA_ADDR + SASA_TAG_OFS);
   assign wr_info  = bus.sasa_wen && (bus.sasa_addr == SASA_ADDR + SASA_INFO_OFS);
   assign wr_flush = bus.sasa_wen && (bus.sasa_addr == SASA_ADDR + SASA_CTRL_OFS)
                     && bus.sasa_data[SASA_FLUSH_BIT];
   assign commit   = wr_info && (state == SASA_TAG_HELD);

   assign new_ent   = sasa_decode_info(tag_q, bus.sasa_data[15:0]);
   assign new_valid = bus.sasa_data[SASA_VALID_BIT] && (new_ent.skip != '0);

   // Tags are unique among valid entries, so OR-encoding the match index is exact.
   always_comb begin
      cm_hit = 1'b0;
      cm_idx = '0;
      for (int unsigned i = 0; i < SASA_ENTRIES; i++) begin
         if (valid[i] && (((entries[i].tag ^ tag_q) & 32'hFFFF_FFFC) == '0)) begin
            cm_hit = 1'b1;
            cm_idx = cm_idx | ptr_t'(i);
         end
      end
   end

   assign slot = cm_hit ? cm_idx : wr_ptr;

   always_comb begin
      look_hit  = 1'b0;
      look_rs1  = '0;
      look_rs2  = '0;
      look_skip = '0;
      look_cond = 1'b0;
      for (int unsigned i = 0; i < SASA_ENTRIES; i++) begin
         if (valid[i] && (((entries[i].tag ^ bus.pc) & 32'hFFFF_FFFC) == '0)) begin
            look_hit  = 1'b1;
            look_rs1  = look_rs1  | entries[i].rs1;
            look_rs2  = look_rs2  | entries[i].rs2;
            look_skip = look_skip | entries[i].skip;
            look_cond = look_cond | entries[i].cond;
         end
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state  <= SASA_IDLE;
         tag_q  <= '0;
         wr_ptr <= '0;
         valid  <= '0;
      end else if (wr_flush) begin
         state  <= SASA_IDLE;
         wr_ptr <= '0;
         valid  <= '0;
      end else if (wr_tag) begin
         tag_q <= bus.sasa_data;
         state <= SASA_TAG_HELD;
      end else if (commit) begin
         valid[slot] <= new_valid;
         if (!cm_hit) wr_ptr <= wr_ptr + ptr_t'(1);
         state <= SASA_IDLE;
      end
   end

   // Payload is only ever observed through its valid bit, so it carries no reset.
   always_ff @(posedge CLK) begin
      if (commit) entries[slot] <= new_ent;
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         hit_q  <= 1'b0;
         rs1_q  <= '0;
         rs2_q  <= '0;
         skip_q <= '0;
         cond_q <= 1'b0;
      end else begin
         hit_q  <= look_hit;
         rs1_q  <= look_rs1;
         rs2_q  <= look_rs2;
         skip_q <= look_skip;
         cond_q <= look_cond;
      end
   end

   assign bus.sasa_hit           = hit_q;
   assign bus.sasa_rs1           = rs1_q;
   assign bus.sasa_rs2           = rs2_q;
   assign bus.sasa_insts_to_skip = skip_q;
   assign bus.sasa_cond          = cond_q;
endmodule

// File: tb/tb_sparce_sasa_table.sv
// Directed bench for sparce_sasa_table: config writes, lookups, wrap, flush and reset cases.
module tb_sparce_sasa_table;
   import rv32i_types_pkg::*;

   localparam word_t TAG_A  = 32'h0000_2000;
   localparam word_t INFO_A = 32'h0000_2004;
   localparam word_t CTRL_A = 32'h0000_2008;
   localparam logic [16:0] MISS = 17'h0;

   logic CLK = 1'b0;
   logic nRST = 1'b0;
   int   vectors = 0;
   int   miscompares = 0;

   sparce_sasa_table_if bus ();

   sparce_sasa_table #(.SASA_ENTRIES(16), .SASA_ADDR(32'h0000_2000)) dut (
      .CLK  (CLK),
      .nRST (nRST),
      .bus  (bus)
   );

   always #5 CLK = ~CLK;

   function automatic word_t info(input logic [4:0] rs1, input logic [4:0] rs2,
                                  input logic [4:0] skip, input logic cond, input logic valid);
      return {15'b0, valid, cond, skip, rs2, rs1};
   endfunction

   function automatic logic [16:0] hitv(input logic [4:0] rs1, input logic [4:0] rs2,
                                        input logic [4:0] skip, input logic cond);
      return {1'b1, rs1, rs2, skip, cond};
   endfunction

   task automatic check(input string name, input logic [16:0] exp);
      logic [16:0] obs;
      obs = {bus.sasa_hit, bus.sasa_rs1, bus.sasa_rs2, bus.sasa_insts_to_skip, bus.sasa_cond};
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", name, obs, exp);
      end
   endtask

   task automatic write(input word_t a, input word_t d);
      @(negedge CLK);
      bus.sasa_addr = a;
      bus.sasa_data = d;
      bus.sasa_wen  = 1'b1;
      @(negedge CLK);
      bus.sasa_wen  = 1'b0;
   endtask

   task automatic commit(input word_t tag, input word_t inf);
      write(TAG_A, tag);
      write(INFO_A, inf);
   endtask

   task automatic lookup(input word_t p, input string name, input logic [16:0] exp);
      @(negedge CLK);
      bus.pc = p;
      @(posedge CLK);
      #1;
      check(name, exp);
   endtask

   initial begin
      bus.pc        = '0;
      bus.sasa_addr = '0;
      bus.sasa_data = '0;
      bus.sasa_wen  = 1'b0;

      repeat (2) @(posedge CLK);
      #1;
      check("reset_outputs", MISS);
      @(negedge CLK);
      nRST = 1'b1;

      // basic commit and lookup
      commit(32'h100, info(5, 6, 3, 0, 1));
      lookup(32'h100, "basic_hit", hitv(5, 6, 3, 0));
      lookup(32'h104, "basic_miss", MISS);

      // same-cycle commit and lookup sees pre-commit state
      write(TAG_A, 32'h500);
      @(negedge CLK);
      bus.pc        = 32'h500;
      bus.sasa_addr = INFO_A;
      bus.sasa_data = info(9, 10, 4, 1, 1);
      bus.sasa_wen  = 1'b1;
      @(posedge CLK);
      #1;
      check("commit_same_cycle", MISS);
      @(negedge CLK);
      bus.sasa_wen = 1'b0;
      @(posedge CLK);
      #1;
      check("commit_next_cycle", hitv(9, 10, 4, 1));

      // INFO in IDLE ignored; skip=0 commits invalidate
      write(INFO_A, info(1, 1, 1, 1, 1));
      lookup(32'h500, "info_idle_no_update", hitv(9, 10, 4, 1));
      lookup(32'h0, "info_idle_no_entry", MISS);
      commit(32'h600, info(2, 3, 0, 0, 1));
      lookup(32'h600, "skip0_new_miss", MISS);
      commit(32'h100, info(5, 6, 0, 0, 1));
      lookup(32'h100, "skip0_inplace_miss", MISS);

      // async reset mid-cycle while TAG is held
      lookup(32'h500, "pre_reset_hit", hitv(9, 10, 4, 1));
      write(TAG_A, 32'h300);
      @(negedge CLK);
      nRST = 1'b0;
      #1;
      check("reset_async_outputs", MISS);
      #2;
      nRST = 1'b1;
      write(INFO_A, info(1, 2, 3, 0, 1));
      lookup(32'h300, "reset_drops_tag", MISS);
      lookup(32'h500, "reset_clears_valid", MISS);

      // 17 commits into 16 entries: oldest evicted
      for (int i = 0; i < 17; i++) begin
         logic [4:0] r1, r2, sk;
         r1 = 5'(i);
         r2 = 5'(31 - i);
         sk = 5'(i + 1);
         commit(word_t'(i * 4), info(r1, r2, sk, r1[0], 1));
      end
      lookup(32'h0, "wrap_oldest_evicted", MISS);
      lookup(32'h40, "wrap_newest_hit", hitv(16, 15, 17, 0));
      lookup(32'h4, "wrap_second_hit", hitv(1, 30, 2, 1));
      lookup(32'h42, "pc_low_bits_ignored", hitv(16, 15, 17, 0));

      // non-flush CTRL and unmapped address are no-ops
      write(CTRL_A, 32'h2);
      lookup(32'h4, "ctrl_bit0_clear", hitv(1, 30, 2, 1));
      write(TAG_A + 32'hC, 32'h1);
      lookup(32'h8, "unmapped_addr", hitv(2, 29, 3, 0));

      // flush from TAG_HELD; same-cycle lookup sees pre-flush state
      write(TAG_A, 32'h700);
      @(negedge CLK);
      bus.pc        = 32'h4;
      bus.sasa_addr = CTRL_A;
      bus.sasa_data = 32'h1;
      bus.sasa_wen  = 1'b1;
      @(posedge CLK);
      #1;
      check("flush_same_cycle", hitv(1, 30, 2, 1));
      @(negedge CLK);
      bus.sasa_wen = 1'b0;
      @(posedge CLK);
      #1;
      check("flush_next_cycle", MISS);
      write(INFO_A, info(1, 1, 1, 0, 1));
      lookup(32'h700, "flush_to_idle", MISS);
      lookup(32'h40, "flush_clears_all", MISS);

      // in-place update advances wr_ptr by one only
      commit(32'h200, info(1, 2, 2, 0, 1));
      commit(32'h200, info(1, 2, 7, 1, 1));
      lookup(32'h200, "inplace_update", hitv(1, 2, 7, 1));
      for (int k = 0; k < 15; k++) begin
         commit(32'h1000 + word_t'(k * 4), info(3, 4, 5, 0, 1));
      end
      lookup(32'h200, "inplace_ptr_not_doubled", hitv(1, 2, 7, 1));
      commit(32'h1100, info(3, 4, 5, 0, 1));
      lookup(32'h200, "inplace_slot_evicted", MISS);
      lookup(32'h1000, "post_flush_fill_hit", hitv(3, 4, 5, 0));
      lookup(32'h1100, "post_flush_wrap_hit", hitv(3, 4, 5, 0));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
